register_writeback_8088: RTL and testbench

REGISTER_WRITEBACK_8088 -- requirements
Module: register_writeback_8088

---
 rtl/register_writeback_8088.sv | 156 +++++++++++++++
 tb/tb_register_writeback_8088.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/register_writeback_8088.sv
// Register write-back stage for an 8088-style core.
// Results from execution are queued in a 4-entry FIFO and drained one
// register-bank write per cycle. An XCHG result expands into two writes.
// Byte writes map the 8088 reg field onto a word register plus a half select.
module register_writeback_8088 (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_w,
  input  logic [2:0]  in_dest,
  input  logic [15:0] in_data,
  input  logic        in_xchg,
  input  logic [2:0]  in_dest2,
  input  logic [15:0] in_data2,
  output logic        en_write,
  output logic [2:0]  reg_write,
  output logic [15:0] write_data,
  output logic        size,
  output logic        select_high_low,
  output logic [2:0]  count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  typedef struct packed {
    logic        w;
    logic [2:0]  dest;
    logic [15:0] data;
    logic        xchg;
    logic [2:0]  dest2;
    logic [15:0] data2;
  } entry_t;

  entry_t      fifo_q [4];
  logic [1:0]  rdPtr_q;
  logic [1:0]  wrPtr_q;
  logic [2:0]  count_q;
  state_t      state_q;
  state_t      state_d;

  entry_t      headEntry;
  entry_t      nextEntry;
  logic        push;
  logic        pop;

  logic        issue_d;
  logic        issueW_d;
  logic [2:0]  issueDest_d;
  logic [15:0] issueData_d;

  // The entry behind the head becomes the new head when the current one pops.
  assign headEntry = fifo_q[rdPtr_q];
  assign nextEntry = fifo_q[rdPtr_q + 2'd1];

  // Readiness looks only at the stored count so a full queue stays closed while draining.
  assign in_ready = reset || (count_q < 3'd4);
  assign push     = in_valid && in_ready && !flush && !reset;
  assign pop      = ((state_q == WR1) && !headEntry.xchg) || (state_q == WR2);

  assign count    = count_q;
  assign busy     = (count_q != 3'd0) || (state_q != IDLE);

  // FIFO storage and pointers; reset and flush both discard every queued entry.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdPtr_q <= 2'd0;
      wrPtr_q <= 2'd0;
      count_q <= 3'd0;
    end else begin
      if (push) begin
        fifo_q[wrPtr_q] <= '{w: in_w, dest: in_dest, data: in_data,
                              xchg: in_xchg, dest2: in_dest2, data2: in_data2};
        wrPtr_q <= wrPtr_q + 2'd1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 2'd1;
      end
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // Choose the next state and which write (if any) goes out on the next cycle.
  always_comb begin
    state_d     = IDLE;
    issue_d     = 1'b0;
    issueW_d    = headEntry.w;
    issueDest_d = headEntry.dest;
    issueData_d = headEntry.data;
    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          state_d = WR1;
          issue_d = 1'b1;
        end
      end
      WR1: begin
        if (headEntry.xchg) begin
          state_d     = WR2;
          issue_d     = 1'b1;
          issueDest_d = headEntry.dest2;
          issueData_d = headEntry.data2;
        end else if (count_q >= 3'd2) begin
          state_d     = WR1;
          issue_d     = 1'b1;
          issueW_d    = nextEntry.w;
          issueDest_d = nextEntry.dest;
          issueData_d = nextEntry.data;
        end
      end
      WR2: begin
        if (count_q >= 3'd2) begin
          state_d     = WR1;
          issue_d     = 1'b1;
          issueW_d    = nextEntry.w;
          issueDest_d = nextEntry.dest;
          issueData_d = nextEntry.data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered write port; write fields hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      en_write        <= 1'b0;
      reg_write       <= 3'd0;
      write_data      <= 16'h0000;
      size            <= 1'b1;
      select_high_low <= 1'b0;
    end else if (flush) begin
      state_q  <= IDLE;
      en_write <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_write <= issue_d;
      if (issue_d) begin
        size <= issueW_d;
        if (issueW_d) begin
          reg_write       <= issueDest_d;
          write_data      <= issueData_d;
          select_high_low <= 1'b0;
        end else begin
          reg_write       <= {1'b0, issueDest_d[1:0]};
          write_data      <= {8'h00, issueData_d[7:0]};
          select_high_low <= issueDest_d[2];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_writeback_8088.sv
// Bench for register_writeback_8088: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_register_writeback_8088;

   logic        clk = 1'b0;
   logic        reset, flush, inValid, inW, inXchg;
   logic [2:0]  inDest, inDest2;
   logic [15:0] inData, inData2;
   logic        inReady, enWrite, size, selHl, busy;
   logic [2:0]  regWrite, count;
   logic [15:0] writeData;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit w;
      int dest;
      int data;
      bit x;
      int dest2;
      int data2;
   } ent_t;

   // Reference model: queued results, writes already strobed for the head, and expected port.
   ent_t mq[$];
   int   done = 0;
   bit   running = 0;
   bit   lastAccepted = 0;
   bit   expEn = 0;
   int   expReg = 0, expData = 0;
   bit   expSize = 1, expHl = 0;

   register_writeback_8088 dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(inValid), .in_ready(inReady),
      .in_w(inW), .in_dest(inDest), .in_data(inData),
      .in_xchg(inXchg), .in_dest2(inDest2), .in_data2(inData2),
      .en_write(enWrite), .reg_write(regWrite), .write_data(writeData),
      .size(size), .select_high_low(selHl),
      .count(count), .busy(busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic modelEdge();
      ent_t e;
      int d, v;
      bit canPush;
      lastAccepted = 0;
      if (reset) begin
         mq.delete(); done = 0; running = 0;
         expEn = 0; expReg = 0; expData = 0; expSize = 1; expHl = 0;
      end else if (flush) begin
         mq.delete(); done = 0; running = 0; expEn = 0;
      end else begin
         canPush = inValid && (mq.size() < 4);
         if (running && done == (mq[0].x ? 2 : 1)) begin
            void'(mq.pop_front());
            done = 0;
         end
         if (mq.size() > 0) begin
            d = (done == 0) ? mq[0].dest : mq[0].dest2;
            v = (done == 0) ? mq[0].data : mq[0].data2;
            expSize = mq[0].w;
            if (mq[0].w) begin
               expReg = d; expData = v; expHl = 0;
            end else begin
               expReg = d % 4; expData = v % 256; expHl = (d >= 4);
            end
            done++;
            running = 1;
            expEn = 1;
         end else begin
            running = 0;
            expEn = 0;
         end
         if (canPush) begin
            e.w = inW; e.dest = inDest; e.data = inData;
            e.x = inXchg; e.dest2 = inDest2; e.data2 = inData2;
            mq.push_back(e);
            lastAccepted = 1;
         end
      end
   endtask

   // Compare every output one step after the edge.
   task automatic compareAll();
      checkOutput("en_write", enWrite, expEn);
      checkOutput("count", count, mq.size());
      checkOutput("busy", busy, (mq.size() != 0) || running);
      checkOutput("in_ready", inReady, reset || (mq.size() < 4));
      checkOutput("reg_write", regWrite, expReg);
      checkOutput("write_data", writeData, expData);
      checkOutput("size", size, expSize);
      checkOutput("select_high_low", selHl, expHl);
   endtask

   // Drive one cycle of inputs, clock it, update the model and check.
   task automatic applyStimulus(input bit v, input bit w, input int dest, input int data,
                                input bit x, input int dest2, input int data2,
                                input bit fl, input bit rs);
      inValid = v; inW = w; inDest = dest[2:0]; inData = data[15:0];
      inXchg = x; inDest2 = dest2[2:0]; inData2 = data2[15:0];
      flush = fl; reset = rs;
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Hold a push until the model reports it accepted, bounded in cycles.
   task automatic pushHeld(input bit w, input int dest, input int data,
                           input bit x, input int dest2, input int data2);
      int tries = 0;
      do begin
         applyStimulus(1, w, dest, data, x, dest2, data2, 0, 0);
         tries++;
      end while (!lastAccepted && tries < 20);
      checkOutput("push_accepted", lastAccepted, 1);
   endtask

   initial begin
      int guard;
      inValid = 0; inW = 1; inDest = 0; inData = 0; inXchg = 0;
      inDest2 = 0; inData2 = 0; flush = 0; reset = 1;

      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 1, 5, 16'h1111, 0, 0, 0, 0, 1);
      idle(2);

      // Single word write with two-cycle latency.
      applyStimulus(1, 1, 0, 16'hABCD, 0, 0, 0, 0, 0);
      idle(4);

      // Two byte writes to the low and high half of the same register.
      applyStimulus(1, 0, 3, 16'h00EF, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 7, 16'h0012, 0, 0, 0, 0, 0);
      idle(4);

      // XCHG, plus an XCHG onto the same destination.
      applyStimulus(1, 1, 2, 16'h3456, 1, 3, 16'h789A, 0, 0);
      idle(4);
      applyStimulus(1, 1, 1, 16'h0101, 1, 1, 16'h0202, 0, 0);
      idle(4);

      // Back-to-back stream, then XCHGs pushed every cycle to fill the queue.
      pushHeld(1, 4, 16'h4444, 0, 0, 0);
      pushHeld(1, 5, 16'h5555, 0, 0, 0);
      pushHeld(1, 6, 16'h6666, 0, 0, 0);
      pushHeld(1, 7, 16'h7777, 0, 0, 0);
      pushHeld(1, 1, 16'h1111, 0, 0, 0);
      idle(6);
      for (int i = 0; i < 7; i++) pushHeld(i[0], i, 16'h1000 + i, 1, 7 - i, 16'h2000 + i);
      checkOutput("full_seen_count", count, mq.size());
      idle(16);

      // Flush while the first half of an XCHG is on the bus.
      applyStimulus(1, 1, 2, 16'hAAAA, 1, 6, 16'hBBBB, 0, 0);
      guard = 0;
      while (!(expEn && done == 1) && guard < 10) begin
         idle(1);
         guard++;
      end
      checkOutput("xchg_first_reached", guard < 10, 1);
      applyStimulus(1, 1, 3, 16'hCCCC, 0, 0, 0, 1, 0);
      idle(3);
      applyStimulus(1, 1, 0, 16'h0D0D, 0, 0, 0, 0, 0);
      idle(4);

      // Reset with several entries queued.
      applyStimulus(1, 1, 1, 16'h1234, 1, 2, 16'h2345, 0, 0);
      applyStimulus(1, 1, 3, 16'h3456, 1, 4, 16'h4567, 0, 0);
      applyStimulus(1, 0, 5, 16'h5678, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 6, 16'h6789, 0, 0, 0, 0, 1);
      idle(4);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                       $urandom_range(0, 16'hFFFF),
                       $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
      end
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
